// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto one valid/ready slave bus, one transfer per grant.
// Optional slave-response watchdog is compiled in when ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  input  logic        err_clr,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   timeout_hit;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    s_valid      = 1'b0;
    s_instr      = 1'b0;
    s_addr       = 32'h0;
    s_wdata      = 32'h0;
    s_wstrb      = 4'h0;
    m0_ready     = 1'b0;
    m0_rdata     = 32'h0;
    m1_ready     = 1'b0;
    m1_rdata     = 32'h0;
    case (state_q)
      IDLE: begin
        // last_grant_q == 1 means master 0 has priority on a tie
        if (m0_valid && (!m1_valid || last_grant_q)) begin
          state_d      = GNT0;
          last_grant_d = 1'b0;
        end else if (m1_valid) begin
          state_d      = GNT1;
          last_grant_d = 1'b1;
        end
      end
      GNT0: begin
        s_valid  = m0_valid;
        s_instr  = m0_instr;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready;
        m0_rdata = s_rdata;
        if (timeout_hit) begin
          s_valid  = 1'b0;
          m0_ready = 1'b1;
          m0_rdata = ERR_RDATA;
        end
        if (!m0_valid || s_ready || timeout_hit) state_d = IDLE;
      end
      GNT1: begin
        s_valid  = m1_valid;
        s_instr  = m1_instr;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready;
        m1_rdata = s_rdata;
        if (timeout_hit) begin
          s_valid  = 1'b0;
          m1_ready = 1'b1;
          m1_rdata = ERR_RDATA;
        end
        if (!m1_valid || s_ready || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset blanks the bus immediately so an in-flight transfer is never completed
    if (rst) begin
      s_valid  = 1'b0;
      s_instr  = 1'b0;
      s_addr   = 32'h0;
      s_wdata  = 32'h0;
      s_wstrb  = 4'h0;
      m0_ready = 1'b0;
      m0_rdata = 32'h0;
      m1_ready = 1'b0;
      m1_rdata = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
  logic        grant_valid;

  assign grant_valid = (state_q == GNT0 && m0_valid) || (state_q == GNT1 && m1_valid);
  assign timeout_hit = grant_valid && !s_ready && (wd_q == WD_LIMIT);

  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (state_q == IDLE && state_d != IDLE) begin
      wd_d = 16'h0;
    end else if (state_q != IDLE && !s_ready) begin
      wd_d = wd_q + 16'h1;
    end
    // Set has priority over a coincident clear
    if (err_clr)     err_d = 1'b0;
    if (timeout_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= 16'h0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q & ~rst;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign timeout_hit    = 1'b0;
  assign err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change 1 time unit after the rising
// edge, outputs are observed on the falling edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_instr;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_ready;
  logic [31:0] m0_rdata;
  logic        m1_valid, m1_instr;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ready;
  logic [31:0] m1_rdata;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        err_clr;
  logic        err_timeout;

  integer checks   = 0;
  integer failures = 0;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .err_clr(err_clr), .err_timeout(err_timeout)
  );

  function automatic logic [206:0] all_outs();
    return {s_valid, s_instr, s_addr, s_wdata, s_wstrb, m0_ready, m0_rdata,
            m1_ready, m1_rdata, err_timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    s_ready  = 1'b0; s_rdata  = 32'h0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    m0_valid = 1'b1; m0_addr = A0; s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF;
    tick(); tick(); settle();
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    settle();
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL post_reset_idle: got %h expected 0", all_outs());
    end
    $display("test_reset: done");
  endtask

  task automatic test_tie_after_reset();
    int n = 0;
    logic got;
    tick();
    m0_valid = 1'b1; m0_addr = A0; m0_instr = 1'b1;
    m1_valid = 1'b1; m1_addr = A1; m1_instr = 1'b0;
    s_ready = 1'b1; s_rdata = 32'h0000_0055;
    for (int cyc = 0; cyc < 30 && n < 6; cyc++) begin
      settle();
      if (s_valid === 1'b1) begin
        got = (s_addr === A1);
        checks++;
        if (got !== 1'(n % 2) || cyc != 2 * n + 1) begin
          failures++;
          $display("FAIL tie_order: grant %0d got master %0d at cycle %0d, expected master %0d at cycle %0d",
                   n, got, cyc, n % 2, 2 * n + 1);
        end
        checks++;
        if (s_instr !== ~got || (got ? m1_ready : m0_ready) !== 1'b1 ||
            (got ? m0_ready : m1_ready) !== 1'b0) begin
          failures++;
          $display("FAIL tie_routing: grant %0d instr=%b m0_ready=%b m1_ready=%b", n, s_instr, m0_ready, m1_ready);
        end
        $display("tie grant %0d -> master %0d at cycle %0d", n, got, cyc);
        n++;
      end
      tick();
    end
    checks++;
    if (n != 6) begin
      failures++;
      $display("FAIL tie_budget: got %0d grants expected 6", n);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_single_read();
    tick();
    m0_valid = 1'b1; m0_addr = 32'h0000_0100;
    settle();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_idle_cycle: s_valid=%b expected 0", s_valid);
    end
    for (int g = 1; g <= 3; g++) begin
      tick();
      if (g == 3) begin s_ready = 1'b1; s_rdata = 32'h1234_5678; end
      settle();
      checks++;
      if (s_valid !== 1'b1 || s_addr !== 32'h0000_0100 || m1_ready !== 1'b0 ||
          m0_ready !== (g == 3) || (g == 3 && m0_rdata !== 32'h1234_5678)) begin
        failures++;
        $display("FAIL single_read: cycle %0d s_valid=%b s_addr=%h m0_ready=%b m0_rdata=%h m1_ready=%b",
                 g, s_valid, s_addr, m0_ready, m0_rdata, m1_ready);
      end
    end
    tick();
    idle_inputs();
    settle();
    checks++;
    if (s_valid !== 1'b0 || m0_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_return_idle: s_valid=%b m0_ready=%b expected 0", s_valid, m0_ready);
    end
    $display("test_single_read: done");
  endtask

  task automatic test_write_routing();
    tick();
    m1_valid = 1'b1; m1_instr = 1'b0; m1_addr = 32'h4000_0000;
    m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0011;
    m0_addr = 32'hFFFF_0000; m0_wdata = 32'h0000_0001; m0_wstrb = 4'hF; m0_instr = 1'b1;
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    settle();
    checks++;
    if (s_valid !== 1'b0 || m1_ready !== 1'b0) begin
      failures++;
      $display("FAIL write_idle: s_valid=%b m1_ready=%b expected 0", s_valid, m1_ready);
    end
    tick();
    settle();
    checks++;
    if (s_valid !== 1'b1 || s_instr !== 1'b0 || s_addr !== 32'h4000_0000 ||
        s_wdata !== 32'hA5A5_A5A5 || s_wstrb !== 4'b0011) begin
      failures++;
      $display("FAIL write_fields: v=%b i=%b a=%h d=%h s=%b", s_valid, s_instr, s_addr, s_wdata, s_wstrb);
    end
    checks++;
    if (m1_ready !== 1'b1 || m1_rdata !== 32'h0BAD_F00D || m0_ready !== 1'b0 || m0_rdata !== 32'h0) begin
      failures++;
      $display("FAIL write_ready: m1_ready=%b m1_rdata=%h m0_ready=%b m0_rdata=%h",
               m1_ready, m1_rdata, m0_ready, m0_rdata);
    end
    tick();
    idle_inputs();
    tick();
    $display("test_write_routing: done");
  endtask

  task automatic test_protocol_violation();
    tick();
    m0_valid = 1'b1; m0_addr = A0;
    tick();
    settle();
    checks++;
    if (s_valid !== 1'b1) begin
      failures++;
      $display("FAIL violation_grant: s_valid=%b expected 1", s_valid);
    end
    tick();
    m0_valid = 1'b0; m1_valid = 1'b1; m1_addr = A1;
    settle();
    checks++;
    if (s_valid !== 1'b0 || m1_ready !== 1'b0) begin
      failures++;
      $display("FAIL violation_drop: s_valid=%b m1_ready=%b expected 0", s_valid, m1_ready);
    end
    tick();
    settle();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL violation_idle: s_valid=%b expected 0", s_valid);
    end
    tick();
    settle();
    checks++;
    if (s_valid !== 1'b1 || s_addr !== A1) begin
      failures++;
      $display("FAIL violation_next_grant: s_valid=%b s_addr=%h expected 1/%h", s_valid, s_addr, A1);
    end
    s_ready = 1'b1;
    tick();
    idle_inputs();
    tick();
    $display("test_protocol_violation: done");
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    tick();
    m0_valid = 1'b1; m0_addr = A0;
    for (int g = 1; g <= 8; g++) begin
      tick();
      settle();
      checks++;
      if (g < 8 && (m0_ready !== 1'b0 || s_valid !== 1'b1 || err_timeout !== 1'b0)) begin
        failures++;
        $display("FAIL timeout_wait: cycle %0d m0_ready=%b s_valid=%b err=%b", g, m0_ready, s_valid, err_timeout);
      end else if (g == 8 && (m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || s_valid !== 1'b0)) begin
        failures++;
        $display("FAIL timeout_expiry: m0_ready=%b m0_rdata=%h s_valid=%b expected 1/deadbeef/0",
                 m0_ready, m0_rdata, s_valid);
      end
    end
    tick();
    m0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++;
      if (err_timeout !== 1'b1) begin
        failures++;
        $display("FAIL timeout_sticky: cycle %0d err_timeout=%b expected 1", k, err_timeout);
      end
      tick();
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: err_timeout=%b expected 0", err_timeout);
    end
    tick();
    m0_valid = 1'b1;
    for (int g = 1; g <= 8; g++) begin
      tick();
      if (g == 8) begin s_ready = 1'b1; s_rdata = 32'h0000_1234; end
      settle();
    end
    checks++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h0000_1234 || s_valid !== 1'b1) begin
      failures++;
      $display("FAIL timeout_boundary: m0_ready=%b m0_rdata=%h s_valid=%b expected 1/00001234/1",
               m0_ready, m0_rdata, s_valid);
    end
    tick();
    idle_inputs();
    settle();
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_boundary_err: err_timeout=%b expected 0", err_timeout);
    end
    tick();
    $display("test_timeout: done");
  endtask
`else
  task automatic test_timeout();
    tick();
    m0_valid = 1'b1; m0_addr = A0;
    tick();
    for (int g = 1; g <= 20; g++) begin
      err_clr = 1'(g % 2);
      settle();
      checks++;
      if (m0_ready !== 1'b0 || s_valid !== 1'b1 || err_timeout !== 1'b0) begin
        failures++;
        $display("FAIL no_watchdog_wait: cycle %0d m0_ready=%b s_valid=%b err=%b", g, m0_ready, s_valid, err_timeout);
      end
      tick();
    end
    err_clr = 1'b0; s_ready = 1'b1; s_rdata = 32'h0000_4321;
    settle();
    checks++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h0000_4321) begin
      failures++;
      $display("FAIL no_watchdog_complete: m0_ready=%b m0_rdata=%h expected 1/00004321", m0_ready, m0_rdata);
    end
    tick();
    idle_inputs();
    tick();
    $display("test_timeout: done");
  endtask
`endif

  task automatic test_reset_mid_grant();
    tick();
    m1_valid = 1'b1; m1_addr = A1;
    tick();
    tick();
    rst = 1'b1; m0_valid = 1'b1; m0_addr = A0; s_ready = 1'b1; s_rdata = 32'h7777_7777;
    settle();
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_mid_grant_same: got %h expected 0", all_outs());
    end
    tick();
    settle();
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_mid_grant_next: got %h expected 0", all_outs());
    end
    tick();
    rst = 1'b0; s_ready = 1'b0;
    settle();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: s_valid=%b expected 0", s_valid);
    end
    tick();
    settle();
    checks++;
    if (s_valid !== 1'b1 || s_addr !== A0) begin
      failures++;
      $display("FAIL reset_release_m0_first: s_valid=%b s_addr=%h expected 1/%h", s_valid, s_addr, A0);
    end
    tick();
    idle_inputs();
    tick();
    $display("test_reset_mid_grant: done");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_tie_after_reset();
    test_single_read();
    test_write_routing();
    test_protocol_violation();
    test_timeout();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
